apb_uart_fifo: RTL and testbench

//  APB-programmable UART, 8 data bits, 1 stop bit, with parametrised TX/RX FIFOs, runtime baud divisor,

---
 rtl/apb_uart_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_apb_uart_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_fifo.sv
// APB-programmable 8-bit UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and a
// registered level interrupt. Define UART_PARITY_EN to add a parity bit (even, or odd via CTRL[4]).
module apb_uart_fifo #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        TX,
    output logic        IRQ
);

    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // APB decode
    logic       access, wr_en, rd_en;
    logic [1:0] addr;
    assign access  = PSEL & PENABLE;
    assign wr_en   = access & PWRITE;
    assign rd_en   = access & ~PWRITE;
    assign addr    = PADDR[3:2];
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{PADDR, PWDATA};

    // Control registers and sticky flags
    logic [3:0]       ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic             tx_ovf_q, rx_ovr_q, frm_err_q;
    logic             par_odd, par_err_rd;

    // FIFOs
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0]   tx_count, rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head;

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_head  = tx_mem[tx_rptr];
    assign tx_push  = wr_en & (addr == 2'd0) & ~tx_full;
    assign rx_pop   = rd_en & (addr == 2'd0) & ~rx_empty;

    // TX/RX FSM state
    state_e           tx_state, rx_state;
    logic [DIV_W-1:0] tx_cnt, tx_div, rx_cnt, rx_div;
    logic [2:0]       tx_bit, rx_bit;
    logic [7:0]       tx_sh, rx_sh;
    logic             tx_q, tx_cnt_end;
    logic             rx_s1, rx_s2, rx_d, rx_fall, rx_sample, rx_par_ok;
    logic             frm_set, par_set;

    assign TX         = tx_q;
    assign tx_cnt_end = (tx_cnt == tx_div - DIV_W'(1));
    assign rx_fall    = rx_d & ~rx_s2;

    // Control register and baud divisor writes
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q <= '0;
            div_q  <= DEF_DIV;
        end else if (wr_en) begin
            if (addr == 2'd2) ctrl_q <= PWDATA[3:0];
            if (addr == 2'd3) div_q  <= (PWDATA[DIV_W-1:0] < MIN_DIV) ? MIN_DIV : PWDATA[DIV_W-1:0];
        end
    end

`ifdef UART_PARITY_EN
    logic par_odd_q, par_err_q, tx_par, rx_par_bad;
    assign par_odd    = par_odd_q;
    assign par_err_rd = par_err_q;
    assign rx_par_ok  = ~rx_par_bad;
    assign par_set    = (rx_state == StParity) & rx_sample & (rx_s2 != (^rx_sh ^ par_odd_q));

    // Parity mode bit and parity error flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (wr_en && addr == 2'd2) par_odd_q <= PWDATA[4];
            par_err_q <= (par_err_q & ~(wr_en && addr == 2'd2 && PWDATA[8])) | par_set;
        end
    end
`else
    assign par_odd    = 1'b0;
    assign par_err_rd = 1'b0;
    assign rx_par_ok  = 1'b1;
    assign par_set    = 1'b0;
`endif

    // Sticky flags: set wins over a same-cycle clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            logic clr;
            clr = wr_en & (addr == 2'd2) & PWDATA[8];
            tx_ovf_q  <= (tx_ovf_q & ~clr) | (wr_en & (addr == 2'd0) & tx_full);
            rx_ovr_q  <= (rx_ovr_q & ~clr) | (rx_push & rx_full);
            frm_err_q <= (frm_err_q & ~clr) | frm_set;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push && !rx_full) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)              rx_rptr <= rx_rptr + AW'(1);
            if ((rx_push && !rx_full) && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
            else if (!(rx_push && !rx_full) && rx_pop) rx_count <= rx_count - (AW+1)'(1);
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge PCLK) begin
        if (tx_push)             tx_mem[tx_wptr] <= PWDATA[7:0];
        if (rx_push && !rx_full) rx_mem[rx_wptr] <= rx_sh;
    end

    // TX pops from IDLE, or at the end of STOP so back-to-back frames have no idle gap
    always_comb begin
        tx_pop = 1'b0;
        if (ctrl_q[0] && !tx_empty)
            tx_pop = (tx_state == StIdle) || ((tx_state == StStop) && tx_cnt_end);
    end

    // TX FSM; divisor latched at frame start so the in-flight frame keeps its timing
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state <= StIdle;
            tx_q     <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= DEF_DIV;
            tx_bit   <= '0;
            tx_sh    <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state <= StStart;
            tx_q     <= 1'b0;
            tx_cnt   <= '0;
            tx_div   <= div_q;
            tx_bit   <= '0;
            tx_sh    <= tx_head;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head ^ par_odd_q;
`endif
        end else begin
            unique case (tx_state)
                StIdle: tx_q <= 1'b1;
                StStart: begin
                    if (tx_cnt_end) begin
                        tx_cnt   <= '0;
                        tx_state <= StData;
                        tx_q     <= tx_sh[0];
                    end else tx_cnt <= tx_cnt + DIV_W'(1);
                end
                StData: begin
                    if (tx_cnt_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_state <= StParity;
                            tx_q     <= tx_par;
`else
                            tx_state <= StStop;
                            tx_q     <= 1'b1;
`endif
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            tx_q   <= tx_sh[1];
                        end
                    end else tx_cnt <= tx_cnt + DIV_W'(1);
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (tx_cnt_end) begin
                        tx_cnt   <= '0;
                        tx_state <= StStop;
                        tx_q     <= 1'b1;
                    end else tx_cnt <= tx_cnt + DIV_W'(1);
                end
`endif
                StStop: begin
                    if (tx_cnt_end) begin
                        tx_cnt   <= '0;
                        tx_state <= StIdle;
                    end else tx_cnt <= tx_cnt + DIV_W'(1);
                end
                default: tx_state <= StIdle;
            endcase
        end
    end

    // RX line synchroniser and edge history
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Start bit sampled at half a bit, later bits one full bit apart (mid-bit)
    always_comb begin
        rx_sample = (rx_cnt == rx_div - DIV_W'(1));
        if (rx_state == StStart) rx_sample = (rx_cnt == (rx_div >> 1));
    end

    assign frm_set = (rx_state == StStop) & rx_sample & ~rx_s2;
    assign rx_push = (rx_state == StStop) & rx_sample & rx_s2 & rx_par_ok;

    // RX FSM
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state   <= StIdle;
            rx_cnt     <= '0;
            rx_div     <= DEF_DIV;
            rx_bit     <= '0;
            rx_sh      <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            unique case (rx_state)
                StIdle: begin
                    rx_cnt <= '0;
                    if (ctrl_q[1] && rx_fall) begin
                        rx_state <= StStart;
                        rx_div   <= div_q;
`ifdef UART_PARITY_EN
                        rx_par_bad <= 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? StIdle : StData;
                    end else rx_cnt <= rx_cnt + DIV_W'(1);
                end
                StData: begin
                    if (rx_sample) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
`ifdef UART_PARITY_EN
                        if (rx_bit == 3'd7) rx_state <= StParity;
`else
                        if (rx_bit == 3'd7) rx_state <= StStop;
`endif
                    end else rx_cnt <= rx_cnt + DIV_W'(1);
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (rx_sample) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= par_set;
                        rx_state   <= StStop;
                    end else rx_cnt <= rx_cnt + DIV_W'(1);
                end
`endif
                StStop: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_state <= StIdle;
                    end else rx_cnt <= rx_cnt + DIV_W'(1);
                end
                default: rx_state <= StIdle;
            endcase
        end
    end

    // Registered interrupt
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) IRQ <= 1'b0;
        else          IRQ <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty);
    end

    // Read mux; DATA reads of an empty RX FIFO return 0
    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            unique case (addr)
                2'd0: PRDATA = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
                2'd1: PRDATA = {16'(rx_count), 7'd0, tx_ovf_q, par_err_rd, frm_err_q, rx_ovr_q,
                                (tx_state != StIdle), rx_empty, rx_full, tx_empty, tx_full};
                2'd2: PRDATA = {27'd0, par_odd, ctrl_q};
                2'd3: PRDATA = 32'(div_q);
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo: registers, TX framing, loopback, FIFO
// overflow, RX framing error, glitch rejection, interrupt and mid-frame reset.
`timescale 1ns/1ps
module tb_apb_uart_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        rx_line, rx_drv, loop, tx, irq;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_BAUD = 32'hC;

`ifdef UART_PARITY_EN
    localparam int          NB        = 11;
    localparam logic [10:0] FRAME_55  = 11'b1_0_01010101_0;
    localparam logic [31:0] CTRL_1F   = 32'h1F;
`else
    localparam int          NB        = 10;
    localparam logic [10:0] FRAME_55  = 11'b0_1_01010101_0;
    localparam logic [31:0] CTRL_1F   = 32'h0F;
`endif

    assign rx_line = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    apb_uart_fifo dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .RX      (rx_line),
        .TX      (tx),
        .IRQ     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick(1);
        penable = 1'b1;
        #1 d = prdata;
        tick(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_tx_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (tx === 1'b0) ok = 1'b1;
            else tick(1);
        end
    endtask

    // Drive one serial frame at 16 cycles per bit
    task automatic send_rx(input logic [7:0] b, input logic par, input logic stop);
        rx_drv = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(16);
        end
`ifdef UART_PARITY_EN
        rx_drv = par;
        tick(16);
`else
        if (par) rx_drv = 1'b1;
`endif
        rx_drv = stop;
        tick(16);
        rx_drv = 1'b1;
        tick(20);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] frame;
        bit          ok;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        rx_drv = 1'b1; loop = 1'b0; rst_n = 1'b0;
        frame = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pready_pslverr", {30'd0, pslverr, pready}, 32'd1);
        read_check("rst_status", A_STAT, 32'h0000_000A);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_baud", A_BAUD, 32'd868);
        read_check("rst_data_empty", A_DATA, 32'h0);

        // Baud clamp and control readback
        apb_write(A_BAUD, 32'd2);
        read_check("baud_clamp", A_BAUD, 32'd4);
        apb_write(A_BAUD, 32'd16);
        read_check("baud_16", A_BAUD, 32'd16);
        apb_write(A_CTRL, 32'h1F);
        read_check("ctrl_rw", A_CTRL, CTRL_1F);

        // TX-empty interrupt
        apb_write(A_CTRL, 32'h8);
        tick(2);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        apb_write(A_CTRL, 32'h0);
        tick(2);
        check("irq_off", {31'd0, irq}, 32'd0);

        // TX frame of 0x55, sampled mid-bit
        apb_write(A_CTRL, 32'h1);
        apb_write(A_DATA, 32'h55);
        wait_tx_low(ok);
        check("tx_start_seen", {31'd0, ok}, 32'd1);
        tick(8);
        for (int k = 0; k < NB; k++) begin
            frame[k] = tx;
            if (k != NB - 1) tick(16);
        end
        check("tx_frame_55", {21'd0, frame}, {21'd0, FRAME_55});
        tick(40);
        read_check("tx_done_status", A_STAT, 32'h0000_000A);

        // Loopback of two bytes with RX interrupt
        loop = 1'b1;
        apb_write(A_CTRL, 32'h7);
        apb_write(A_DATA, 32'hA5);
        apb_write(A_DATA, 32'h3C);
        read_check("loop_busy_status", A_STAT, 32'h0000_0018);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (irq === 1'b1) ok = 1'b1;
            else tick(1);
        end
        check("loop_irq_rise", {31'd0, ok}, 32'd1);
        tick(400);
        read_check("loop_status", A_STAT, 32'h0002_0002);
        read_check("loop_rd0", A_DATA, 32'hA5);
        read_check("loop_rd1", A_DATA, 32'h3C);
        read_check("loop_rd_empty", A_DATA, 32'h0);
        tick(2);
        check("loop_irq_fall", {31'd0, irq}, 32'd0);
        loop = 1'b0;
        apb_write(A_CTRL, 32'h0);

        // TX FIFO overflow and sticky clear
        for (int i = 0; i < 17; i++) apb_write(A_DATA, 32'(i));
        read_check("ovf_status", A_STAT, 32'h0000_0109);
        apb_write(A_CTRL, 32'h100);
        read_check("clr_ctrl_read", A_CTRL, 32'h0);
        read_check("clr_status", A_STAT, 32'h0000_0009);

        // Reset in the middle of a frame
        apb_write(A_CTRL, 32'h1);
        wait_tx_low(ok);
        check("rst_frame_start", {31'd0, ok}, 32'd1);
        tick(40);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        read_check("midrst_status", A_STAT, 32'h0000_000A);
        read_check("midrst_ctrl", A_CTRL, 32'h0);
        read_check("midrst_baud", A_BAUD, 32'd868);

        // RX path: good frame, framing error, glitch
        apb_write(A_BAUD, 32'd16);
        apb_write(A_CTRL, 32'h2);
        send_rx(8'h3C, 1'b0, 1'b1);
        read_check("rx_good_status", A_STAT, 32'h0001_0002);
        read_check("rx_good_data", A_DATA, 32'h3C);
        send_rx(8'h81, 1'b0, 1'b0);
        read_check("rx_frm_status", A_STAT, 32'h0000_004A);
        apb_write(A_CTRL, 32'h102);
        read_check("rx_frm_clr", A_STAT, 32'h0000_000A);
        read_check("rx_ctrl_keep", A_CTRL, 32'h2);
        rx_drv = 1'b0;
        tick(8);
        rx_drv = 1'b1;
        tick(200);
        read_check("rx_glitch", A_STAT, 32'h0000_000A);

`ifdef UART_PARITY_EN
        // Odd parity: 0x03 has two ones, so parity bit 1 is correct
        apb_write(A_CTRL, 32'h12);
        send_rx(8'h03, 1'b1, 1'b1);
        read_check("par_ok_status", A_STAT, 32'h0001_0002);
        read_check("par_ok_data", A_DATA, 32'h03);
        send_rx(8'h03, 1'b0, 1'b1);
        read_check("par_bad_status", A_STAT, 32'h0000_008A);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
